mem_arbiter: RTL

Two-port arbiter and sequencer for the shared 256-byte `Memory` RAM. Port 0 is the CPU bus interface; port 1 is the DMA/console loader. Both reach the single RAM through this block. It accepts one request at a time, latches it, and drives the RAM for exactly one cycle. It then returns an acknowledge and, for reads, registered read data to the winning requester.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 256-byte RAM: IDLE -> ACCESS -> DONE per request.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    // Handshake: reqN is a level held until ackN; ackN is a one-cycle pulse in DONE.
    // Requests are sampled only in IDLE, so fields may change once the request is latched.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   lat_we;
    logic   lat_port;
    logic   grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_port;

    always_comb begin
        grant = 1'b0;
        if (req0 && req1) grant = ~last_port;
        else if (req1)    grant = 1'b1;
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_port    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_port   <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_port    <= grant;
                        lat_we      <= grant ? we1 : we0;
                        mem_address <= grant ? addr1 : addr0;
                        mem_data_in <= grant ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_port   <= grant;
`endif
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (lat_port) rdata1 <= mem_data_out;
                        else          rdata0 <= mem_data_out;
                    end
                    ack0  <= ~lat_port;
                    ack1  <= lat_port;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset gates the strobe combinationally so a write in flight is never committed.
    assign mem_write_en = (state == ACCESS) && lat_we && !reset;
    assign busy         = (state != IDLE);

endmodule
